// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS64 load/store path: access sizes, memwrite codes, controller states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mips_mem_pkg;

    // CPU access size codes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_W = 2'd1;
    localparam logic [1:0] SZ_D = 2'd2;

    // memwrite strobe codes seen by the mem data port
    localparam logic [1:0] MW_NONE  = 2'd0;
    localparam logic [1:0] MW_WORD  = 2'd1;
    localparam logic [1:0] MW_BYTE  = 2'd2;
    localparam logic [1:0] MW_DWORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2,
        WAIT  = 2'd3
    } ctrl_state_t;

    // Illegal size or address not naturally aligned for the access size.
    function automatic logic access_bad(input logic [1:0] sz, input logic [2:0] lo);
        logic bad;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_W:    bad = (lo[1:0] != 2'b00);
            SZ_D:    bad = (lo != 3'b000);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Map an access size onto the memwrite code; only called for legal sizes.
    function automatic logic [1:0] mw_code(input logic [1:0] sz);
        logic [1:0] code;
        case (sz)
            SZ_B:    code = MW_BYTE;
            SZ_W:    code = MW_WORD;
            default: code = MW_DWORD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the CPU request/response signals and the mem data-port strobes around mem_ctrl.
// Latency: n/a (wires only).
// Backpressure: CPU side sees busy/done; mem side is the ready low->high round trip.
// master = the load/store controller; slave = the environment (CPU plus mem).
interface mem_ctrl_if #(
    parameter int N = 64
);
    // CPU side
    logic         req;
    logic         we;
    logic [1:0]   size;
    logic         uns;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] rdata;
    // mem side
    logic         dword;
    logic         memread;
    logic [1:0]   memwrite;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic [N-1:0] readdata;
    logic         ready;

    modport master (
        input  req, we, size, uns, addr, wdata, readdata, ready,
        output busy, done, err, rdata, dword, memread, memwrite, dataadr, writedata
    );

    modport slave (
        output req, we, size, uns, addr, wdata, readdata, ready,
        input  busy, done, err, rdata, dword, memread, memwrite, dataadr, writedata
    );
endinterface

// File: rtl/mem_ctrl_load_align.sv
// Load extraction: picks byte/word/dword out of readdata (big-endian in the low 32-bit word) and extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: readdata (raw mem data), offset (addr[1:0]), size (SZ_*), uns (1 = zero-extend) -> value.
module load_align
    import mips_mem_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] readdata,
    input  logic [1:0]   offset,
    input  logic [1:0]   size,
    input  logic         uns,
    output logic [N-1:0] value
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = readdata[7:0];
        value    = readdata;
        // Byte offset 0 is the most significant byte of the word.
        case (offset)
            2'd0:    byte_sel = readdata[31:24];
            2'd1:    byte_sel = readdata[23:16];
            2'd2:    byte_sel = readdata[15:8];
            default: byte_sel = readdata[7:0];
        endcase
        case (size)
            SZ_B:    value = {{(N-8){byte_sel[7] & ~uns}}, byte_sel};
            SZ_W:    value = {{(N-32){readdata[31] & ~uns}}, readdata[31:0]};
            default: value = readdata;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store initiator between the MIPS64 datapath and the mem data port, with watchdog abort.
// Latency: strobe 1 cycle after accept, done 1 cycle after ready returns; alignment error done 1 cycle after accept.
// Backpressure: req only taken in IDLE with ready high, otherwise dropped; busy tells the CPU.
// Ports: clk, reset (async, active high), bus (mem_ctrl_if.master: CPU req/we/size/uns/addr/wdata ->
//        busy/done/err/rdata; mem dword/memread/memwrite/dataadr/writedata <- readdata/ready).
// TIMEOUT must be at least 2.
module mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    mem_ctrl_if.master      bus
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

    ctrl_state_t  state;
    logic [WDW-1:0] wd;
    logic         err_pend;   // misaligned/illegal request waiting one cycle to report
    logic         l_we;
    logic         l_uns;
    logic [1:0]   l_size;
    logic [1:0]   l_off;
    logic [N-1:0] aligned;
    logic         req_bad;

    assign req_bad  = access_bad(bus.size, bus.addr[2:0]);
    assign bus.busy = (state != IDLE) || !bus.ready;

    load_align #(.N(N)) u_load_align (
        .readdata (bus.readdata),
        .offset   (l_off),
        .size     (l_size),
        .uns      (l_uns),
        .value    (aligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wd            <= '0;
            err_pend      <= 1'b0;
            l_we          <= 1'b0;
            l_uns         <= 1'b0;
            l_size        <= SZ_B;
            l_off         <= 2'd0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rdata     <= '0;
            bus.dword     <= 1'b0;
            bus.memread   <= 1'b0;
            bus.memwrite  <= MW_NONE;
            bus.dataadr   <= '0;
            bus.writedata <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (err_pend) begin
                        // Block acceptance this cycle so done pulses never run back to back.
                        err_pend <= 1'b0;
                        bus.done <= 1'b1;
                        bus.err  <= 1'b1;
                    end else if (bus.req && bus.ready) begin
                        if (req_bad) begin
                            err_pend <= 1'b1;
                        end else begin
                            l_we          <= bus.we;
                            l_uns         <= bus.uns;
                            l_size        <= bus.size;
                            l_off         <= bus.addr[1:0];
                            bus.dataadr   <= bus.addr;
                            bus.writedata <= bus.wdata;
                            // Strobes go out registered so they are high for the ISSUE cycle only.
                            if (bus.we) begin
                                bus.memwrite <= mw_code(bus.size);
                            end else begin
                                bus.memread <= 1'b1;
                                bus.dword   <= (bus.size == SZ_D);
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // mem re-arms on a held strobe, so drop it after exactly one cycle.
                    bus.memread  <= 1'b0;
                    bus.memwrite <= MW_NONE;
                    wd           <= '0;
                    state        <= ACK;
                end
                ACK: begin
                    if (!bus.ready) begin
                        wd    <= wd + WDW'(1);
                        state <= WAIT;
                    end else if (wd == WD_MAX) begin
                        bus.done  <= 1'b1;
                        bus.err   <= 1'b1;
                        bus.dword <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                WAIT: begin
                    // A completion arriving on the timeout edge still counts as a success.
                    if (bus.ready) begin
                        if (!l_we) begin
                            bus.rdata <= aligned;
                        end
                        bus.done  <= 1'b1;
                        bus.dword <= 1'b0;
                        state     <= IDLE;
                    end else if (wd == WD_MAX) begin
                        bus.done  <= 1'b1;
                        bus.err   <= 1'b1;
                        bus.dword <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl against a 20-count negedge mem responder, plus a watchdog instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_ctrl;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if #(.N(64)) mif ();
    mem_ctrl_if #(.N(64)) wif ();

    mem_ctrl #(.N(64), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (mif)
    );

    mem_ctrl #(.N(64), .TIMEOUT(8)) dut_wd (
        .clk   (clk),
        .reset (rst),
        .bus   (wif)
    );

    // Watchdog instance: responder that never drops ready.
    assign wif.ready    = 1'b1;
    assign wif.readdata = 64'h0;

    // ---------------- mem responder (negedge, 20-count) ----------------
    logic        mem_ready = 1'b1;
    logic [63:0] mem_rdata = 64'h0;
    logic [63:0] ram [0:15];
    int          cnt = 0;
    logic        p_rd = 1'b0;
    logic        p_dw = 1'b0;
    logic [1:0]  p_mw = 2'd0;
    logic [63:0] p_adr = 64'h0;
    logic [63:0] p_wd = 64'h0;
    int          pos;
    logic [31:0] wsel;

    assign mif.ready    = mem_ready;
    assign mif.readdata = mem_rdata;

    always @(negedge clk) begin
        if (mem_ready && (mif.memread === 1'b1 || (mif.memwrite !== 2'd0 && !$isunknown(mif.memwrite)))) begin
            mem_ready <= 1'b0;
            cnt       <= 19;
            p_rd      <= mif.memread;
            p_dw      <= mif.dword;
            p_mw      <= mif.memwrite;
            p_adr     <= mif.dataadr;
            p_wd      <= mif.writedata;
        end else if (!mem_ready) begin
            if (cnt == 0) begin
                mem_ready <= 1'b1;
                wsel = p_adr[2] ? ram[p_adr[6:3]][63:32] : ram[p_adr[6:3]][31:0];
                if (p_rd) begin
                    // Junk in the upper half checks that sub-dword loads ignore it.
                    mem_rdata <= p_dw ? ram[p_adr[6:3]] : {32'hDEADBEEF, wsel};
                end else begin
                    case (p_mw)
                        2'd3: ram[p_adr[6:3]] <= p_wd;
                        2'd1: begin
                            if (p_adr[2]) ram[p_adr[6:3]][63:32] <= p_wd[31:0];
                            else          ram[p_adr[6:3]][31:0]  <= p_wd[31:0];
                        end
                        2'd2: begin
                            pos = 8 * (3 - int'(p_adr[1:0])) + (p_adr[2] ? 32 : 0);
                            ram[p_adr[6:3]][pos +: 8] <= p_wd[7:0];
                        end
                        default: ;
                    endcase
                end
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Results of the last do_req
    int          r_cyc;
    logic        r_err;
    logic [63:0] r_rdata;
    logic        mr0, dw0, mr1, busy1, done_next;
    logic [1:0]  mw0, mw1;
    logic [63:0] adr0, wd0;

    // Accept edge is posedge 0; r_cyc is the posedge at which done was registered.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        mif.req = 1'b1; mif.we = w; mif.size = sz; mif.uns = u; mif.addr = a; mif.wdata = d;
        @(posedge clk); #1;
        mr0 = mif.memread; mw0 = mif.memwrite; dw0 = mif.dword;
        adr0 = mif.dataadr; wd0 = mif.writedata;
        @(negedge clk);
        mif.req = 1'b0;
        r_cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                mr1 = mif.memread; mw1 = mif.memwrite; busy1 = mif.busy;
            end
            if (mif.done) begin
                r_cyc = i;
                break;
            end
        end
        r_err = mif.err; r_rdata = mif.rdata;
        @(posedge clk); #1;
        done_next = mif.done;
    endtask

    int wd_cyc;
    int wd_extra;
    int strobes;
    int rdy_wait;

    initial begin
        mif.req = 1'b0; mif.we = 1'b0; mif.size = SZ_B; mif.uns = 1'b0;
        mif.addr = 64'h0; mif.wdata = 64'h0;
        wif.req = 1'b0; wif.we = 1'b0; wif.size = SZ_B; wif.uns = 1'b0;
        wif.addr = 64'h0; wif.wdata = 64'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", mif.done, 1'b0);
        chk("rst_err", mif.err, 1'b0);
        chk("rst_rdata", mif.rdata, 64'h0);
        chk("rst_mr", mif.memread, 1'b0);
        chk("rst_mw", mif.memwrite, MW_NONE);
        chk("rst_dw", mif.dword, 1'b0);
        chk("rst_adr", mif.dataadr, 64'h0);
        chk("rst_wdat", mif.writedata, 64'h0);
        chk("rst_busy", mif.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // sw 0x11223344 @0x10
        do_req(1'b1, SZ_W, 1'b0, 64'h10, 64'h11223344);
        chk("sw_mw0", mw0, MW_WORD);
        chk("sw_mw1", mw1, MW_NONE);
        chk("sw_cyc", 64'(r_cyc), 64'd21);
        chk("sw_err", r_err, 1'b0);

        // lbu 0x13 -> 0x44
        do_req(1'b0, SZ_B, 1'b1, 64'h13, 64'h0);
        chk("lbu_mr0", mr0, 1'b1);
        chk("lbu_dw0", dw0, 1'b0);
        chk("lbu_mr1", mr1, 1'b0);
        chk("lbu_busy", busy1, 1'b1);
        chk("lbu_cyc", 64'(r_cyc), 64'd21);
        chk("lbu_dat", r_rdata, 64'h44);
        chk("lbu_err", r_err, 1'b0);
        chk("lbu_pulse", done_next, 1'b0);

        // lb 0x10 with word 0x80000000
        do_req(1'b1, SZ_W, 1'b0, 64'h10, 64'h80000000);
        do_req(1'b0, SZ_B, 1'b0, 64'h10, 64'h0);
        chk("lb_dat", r_rdata, 64'hFFFF_FFFF_FFFF_FF80);

        // lw / lwu 0x8 with word 0x80000001
        do_req(1'b1, SZ_W, 1'b0, 64'h8, 64'h80000001);
        do_req(1'b0, SZ_W, 1'b0, 64'h8, 64'h0);
        chk("lw_dat", r_rdata, 64'hFFFF_FFFF_8000_0001);
        chk("lw_cyc", 64'(r_cyc), 64'd21);
        do_req(1'b0, SZ_W, 1'b1, 64'h8, 64'h0);
        chk("lwu_dat", r_rdata, 64'h0000_0000_8000_0001);

        // sd then ld
        do_req(1'b1, SZ_D, 1'b0, 64'h10, 64'h0123_4567_89AB_CDEF);
        chk("sd_mw0", mw0, MW_DWORD);
        chk("sd_mw1", mw1, MW_NONE);
        chk("sd_adr", adr0, 64'h10);
        chk("sd_wdat", wd0, 64'h0123_4567_89AB_CDEF);
        do_req(1'b0, SZ_D, 1'b0, 64'h10, 64'h0);
        chk("ld_dw0", dw0, 1'b1);
        chk("ld_dat", r_rdata, 64'h0123_4567_89AB_CDEF);
        chk("ld_err", r_err, 1'b0);

        // sb 0x55 @0x11 (big-endian byte 1 of the low word)
        do_req(1'b1, SZ_B, 1'b0, 64'h11, 64'hFFFF_FFFF_FFFF_FF55);
        chk("sb_mw0", mw0, MW_BYTE);
        do_req(1'b0, SZ_W, 1'b0, 64'h10, 64'h0);
        chk("lw2_dat", r_rdata, 64'hFFFF_FFFF_8955_CDEF);
        do_req(1'b0, SZ_B, 1'b0, 64'h11, 64'h0);
        chk("lb1_dat", r_rdata, 64'h55);
        do_req(1'b0, SZ_B, 1'b1, 64'h10, 64'h0);
        chk("lbu0_dat", r_rdata, 64'h89);

        // Alignment and illegal-size errors
        do_req(1'b0, SZ_W, 1'b0, 64'h6, 64'h0);
        chk("lw6_mr0", mr0, 1'b0);
        chk("lw6_cyc", 64'(r_cyc), 64'd1);
        chk("lw6_err", r_err, 1'b1);
        chk("lw6_rdat", r_rdata, 64'h89);
        chk("lw6_pulse", done_next, 1'b0);
        do_req(1'b0, SZ_D, 1'b0, 64'h4, 64'h0);
        chk("ld4_mr0", mr0, 1'b0);
        chk("ld4_cyc", 64'(r_cyc), 64'd1);
        chk("ld4_err", r_err, 1'b1);
        do_req(1'b1, 2'd3, 1'b0, 64'h0, 64'h0);
        chk("sz3_mw0", mw0, MW_NONE);
        chk("sz3_err", r_err, 1'b1);

        // Watchdog: ready never drops, TIMEOUT=8
        @(negedge clk);
        wif.req = 1'b1; wif.we = 1'b0; wif.size = SZ_D; wif.addr = 64'h0;
        @(posedge clk); #1;
        chk("wd_mr0", wif.memread, 1'b1);
        @(negedge clk);
        wif.req = 1'b0;
        wd_cyc = -1;
        wd_extra = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (wif.memread) wd_extra++;
            if (wif.done) begin
                wd_cyc = i;
                break;
            end
        end
        chk("wd_cyc", 64'(wd_cyc), 64'd10);
        chk("wd_err", wif.err, 1'b1);
        chk("wd_mrlow", 64'(wd_extra), 64'd0);

        // Reset in WAIT
        @(negedge clk);
        mif.req = 1'b1; mif.we = 1'b0; mif.size = SZ_D; mif.uns = 1'b0; mif.addr = 64'h10;
        @(posedge clk);
        @(negedge clk);
        mif.req = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_done", mif.done, 1'b0);
        chk("ar_rdata", mif.rdata, 64'h0);
        chk("ar_adr", mif.dataadr, 64'h0);
        chk("ar_dw", mif.dword, 1'b0);
        chk("ar_busy", mif.busy, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        mif.req = 1'b1;
        strobes = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mif.memread || mif.done) strobes++;
        end
        chk("ar_ignore", 64'(strobes), 64'd0);
        @(negedge clk);
        mif.req = 1'b0;
        rdy_wait = 0;
        while (!mem_ready && rdy_wait < 50) begin
            @(negedge clk);
            rdy_wait++;
        end
        chk("ar_rdy", mem_ready, 1'b1);
        do_req(1'b0, SZ_D, 1'b0, 64'h10, 64'h0);
        chk("ar_ld_dat", r_rdata, 64'h0123_4567_8955_CDEF);
        chk("ar_ld_cyc", 64'(r_cyc), 64'd21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
